// File: rtl/reflector_prog_if.sv
// Handshake bundle for the programmable reflector: letter translation path plus
// pair-load configuration channel.
interface reflector_prog_if #(
  parameter int N = 26,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic [N-1:0] in_onehot;
  logic         out_valid;
  logic [N-1:0] out_onehot;
  logic         out_err;
  logic         cfg_start;
  logic         cfg_valid;
  logic [W-1:0] cfg_a;
  logic [W-1:0] cfg_b;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;

  modport slave (
    input  in_valid, in_onehot, cfg_start, cfg_valid, cfg_a, cfg_b,
    output out_valid, out_onehot, out_err, cfg_ready, cfg_done, cfg_err
  );

  modport master (
    output in_valid, in_onehot, cfg_start, cfg_valid, cfg_a, cfg_b,
    input  out_valid, out_onehot, out_err, cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/reflector_prog.sv
// Reciprocal letter reflector with a run-time loadable pairing table. Letters are
// translated through the active table while a new wiring is built in a shadow copy.
module reflector_prog #(
  parameter int N = 26,
  parameter int W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  reflector_prog_if.slave bus
);
  localparam int             CW        = $clog2(N / 2 + 1);
  localparam logic [CW-1:0]  LAST_PAIR = CW'(N / 2 - 1);
  localparam logic [W:0]     N_LIM     = (W + 1)'(N);
  localparam logic [N-1:0]   ONE_N     = {{(N - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, LOAD, COMMIT} state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  active_reg [N];
  logic [W-1:0]  shadow_reg [N];
  logic [N-1:0]  used_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          cfg_err_reg, cfg_err_next;
  logic          clear_load, pair_write, commit;
  logic          pair_good;

  logic          out_valid_reg, out_err_reg;
  logic [N-1:0]  out_onehot_reg;
  logic [W-1:0]  in_idx;
  logic          in_single;
  logic [N-1:0]  mapped_onehot;

  // Range checks gate the used-bit lookups so an out-of-range index never decides acceptance.
  always_comb begin
    pair_good = ({1'b0, bus.cfg_a} < N_LIM) && ({1'b0, bus.cfg_b} < N_LIM) &&
                (bus.cfg_a != bus.cfg_b);
    if (pair_good)
      pair_good = !used_reg[bus.cfg_a] && !used_reg[bus.cfg_b];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= RUN;
      count_reg   <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    cfg_err_next = cfg_err_reg;
    clear_load   = 1'b0;
    pair_write   = 1'b0;
    commit       = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.cfg_start) begin
          state_next   = LOAD;
          clear_load   = 1'b1;
          count_next   = '0;
          cfg_err_next = 1'b0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          clear_load   = 1'b1;
          count_next   = '0;
          cfg_err_next = 1'b0;
        end else if (bus.cfg_valid) begin
          if (pair_good) begin
            pair_write = 1'b1;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_PAIR)
              state_next = COMMIT;
          end else begin
            cfg_err_next = 1'b1;
            state_next   = RUN;
          end
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      logic hit;
      assign hit = pair_write && ((bus.cfg_a == W'(gi)) || (bus.cfg_b == W'(gi)));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          active_reg[gi] <= W'(N - 1 - gi);
          shadow_reg[gi] <= W'(N - 1 - gi);
          used_reg[gi]   <= 1'b0;
        end else begin
          if (commit)
            active_reg[gi] <= shadow_reg[gi];
          if (hit)
            shadow_reg[gi] <= (bus.cfg_a == W'(gi)) ? bus.cfg_b : bus.cfg_a;
          if (clear_load)
            used_reg[gi] <= 1'b0;
          else if (hit)
            used_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    in_idx = '0;
    for (int i = 0; i < N; i++)
      if (bus.in_onehot[i])
        in_idx = W'(i);
    in_single     = (bus.in_onehot != '0) && ((bus.in_onehot & (bus.in_onehot - ONE_N)) == '0);
    mapped_onehot = ONE_N << active_reg[in_idx];
  end

  // Translation always reads the active table, so a commit only affects the next sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      out_onehot_reg <= '0;
      out_err_reg    <= 1'b0;
    end else begin
      out_valid_reg  <= bus.in_valid;
      out_onehot_reg <= (bus.in_valid && in_single) ? mapped_onehot : '0;
      out_err_reg    <= bus.in_valid && !in_single;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_onehot = out_onehot_reg;
  assign bus.out_err    = out_err_reg;
  assign bus.cfg_ready  = (state_reg == LOAD);
  assign bus.cfg_done   = (state_reg == COMMIT);
  assign bus.cfg_err    = cfg_err_reg;
endmodule

// File: tb/tb_reflector_prog.sv
// Self-checking bench for reflector_prog: directed wiring loads and bad pairs plus
// randomized traffic against a pairing-table reference model.
module tb_reflector_prog;
  localparam int N = 26;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reflector_prog_if #(.N(N), .W(W)) bus ();

  reflector_prog #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int check_count = 0;
  int error_count = 0;
  int done_count  = 0;

  // Reference model: the wiring in use, the wiring under construction, and load progress.
  int act_m [N];
  int pend_m [N];
  bit used_m [N];
  int pairs_m;
  bit loading_m, committing_m, err_m;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      act_m[i]  = N - 1 - i;
      pend_m[i] = N - 1 - i;
      used_m[i] = 1'b0;
    end
    pairs_m = 0;
    loading_m = 1'b0;
    committing_m = 1'b0;
    err_m = 1'b0;
  endfunction

  function automatic void model_clock(input bit st, input bit cv, input int a, input int b);
    if (committing_m) begin
      act_m = pend_m;
      committing_m = 1'b0;
    end else if (st) begin
      loading_m = 1'b1;
      pairs_m = 0;
      err_m = 1'b0;
      for (int i = 0; i < N; i++) used_m[i] = 1'b0;
    end else if (loading_m && cv) begin
      if (a != b && a < N && b < N && !used_m[a] && !used_m[b]) begin
        pend_m[a] = b;
        pend_m[b] = a;
        used_m[a] = 1'b1;
        used_m[b] = 1'b1;
        pairs_m++;
        if (pairs_m == N / 2) begin
          loading_m = 1'b0;
          committing_m = 1'b1;
        end
      end else begin
        err_m = 1'b1;
        loading_m = 1'b0;
      end
    end
  endfunction

  // One clock: drive at the falling edge, let the rising edge act, check at the next falling edge.
  task automatic cycle(input bit iv, input logic [N-1:0] ioh, input bit st, input bit cv,
                       input int a, input int b);
    logic [N-1:0] exp_oh;
    bit exp_err;
    bus.in_valid  = iv;
    bus.in_onehot = ioh;
    bus.cfg_start = st;
    bus.cfg_valid = cv;
    bus.cfg_a     = W'(a);
    bus.cfg_b     = W'(b);
    exp_oh  = '0;
    exp_err = 1'b0;
    if (iv) begin
      if ($countones(ioh) == 1) begin
        for (int i = 0; i < N; i++)
          if (ioh[i]) exp_oh[act_m[i]] = 1'b1;
      end else begin
        exp_err = 1'b1;
      end
    end
    model_clock(st, cv, a % (1 << W), b % (1 << W));
    @(posedge clk);
    @(negedge clk);
    check_value("out_valid", 32'(bus.out_valid), 32'(iv));
    check_value("out_onehot", 32'(bus.out_onehot), 32'(exp_oh));
    check_value("out_err", 32'(bus.out_err), 32'(exp_err));
    check_value("cfg_ready", 32'(bus.cfg_ready), 32'(loading_m));
    check_value("cfg_done", 32'(bus.cfg_done), 32'(committing_m));
    check_value("cfg_err", 32'(bus.cfg_err), 32'(err_m));
    if (bus.cfg_done) done_count++;
    if (st || cv)
      $display("cfg t=%0t start=%0b valid=%0b a=%0d b=%0d ready=%0b done=%0b err=%0b",
               $time, st, cv, a, b, bus.cfg_ready, bus.cfg_done, bus.cfg_err);
  endtask

  function automatic logic [N-1:0] letter(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, 0);
  endtask

  task automatic translate_const(input string tag, input int from, input int to);
    cycle(1, letter(from), 0, 0, 0, 0);
    check_value(tag, 32'(bus.out_onehot), 32'(letter(to)));
  endtask

  int pa [13] = '{0, 1, 2, 3, 4, 5, 7, 11, 13, 16, 17, 18, 24};
  int pb [13] = '{20, 22, 9, 14, 6, 10, 8, 12, 15, 19, 23, 21, 25};

  initial begin
    int done_before;
    int q [$];
    int x, y, k;
    model_reset();
    bus.in_valid = 1'b0; bus.in_onehot = '0; bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_a = '0; bus.cfg_b = '0;
    repeat (3) @(negedge clk);
    check_value("rst_ready", 32'(bus.cfg_ready), 32'd0);
    check_value("rst_out", 32'(bus.out_onehot), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // Default wiring and back-to-back streaming.
    translate_const("def_0", 0, 25);
    translate_const("def_12", 12, 13);
    for (int i = 0; i < N; i++) cycle(1, letter(i), 0, 0, 0, 0);

    // Bad pairs leave the default wiring in place.
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 0, 1, 3, 3);
    check_value("bad_same", 32'(bus.cfg_err), 32'd1);
    translate_const("bad_same_map", 0, 25);
    cycle(0, '0, 1, 0, 0, 0);
    check_value("err_cleared", 32'(bus.cfg_err), 32'd0);
    cycle(0, '0, 0, 1, 0, 5);
    cycle(0, '0, 0, 1, 5, 7);
    check_value("bad_reuse", 32'(bus.cfg_err), 32'd1);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 0, 1, 26, 1);
    check_value("bad_range", 32'(bus.cfg_err), 32'd1);
    idle(2);
    check_value("bad_no_done", 32'(done_count), 32'd0);
    translate_const("bad_map", 0, 25);

    // Full load with letters streaming across it, including the commit cycle.
    k = 0;
    cycle(1, letter(k % N), 1, 0, 0, 0); k++;
    for (int p = 0; p < 13; p++) begin
      cycle(1, letter(k % N), 0, 1, pa[p], pb[p]); k++;
    end
    cycle(1, letter(0), 0, 0, 0, 0);
    check_value("commit_old", 32'(bus.out_onehot), 32'(letter(25)));
    translate_const("new_0", 0, 20);
    translate_const("new_20", 20, 0);
    translate_const("new_24", 24, 25);
    check_value("load_done_once", 32'(done_count), 32'd1);
    for (int i = 0; i < N; i++) cycle(1, letter(i), 0, 0, 0, 0);

    // Malformed inputs.
    cycle(1, N'(3), 0, 0, 0, 0);
    check_value("mal_3_err", 32'(bus.out_err), 32'd1);
    cycle(1, '0, 0, 0, 0, 0);
    check_value("mal_0_err", 32'(bus.out_err), 32'd1);

    // Reset mid-load after six pairs.
    cycle(0, '0, 1, 0, 0, 0);
    for (int p = 0; p < 6; p++) cycle(0, '0, 0, 1, pa[p], pb[p]);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_value("async_rst_ready", 32'(bus.cfg_ready), 32'd0);
    #3 reset_n = 1'b1;
    @(negedge clk);
    translate_const("rst_map", 0, 25);

    // Restart mid-load: the restarted load needs all 13 pairs.
    done_before = done_count;
    cycle(0, '0, 1, 0, 0, 0);
    for (int p = 0; p < 4; p++) cycle(0, '0, 0, 1, pa[p], pb[p]);
    cycle(0, '0, 1, 1, 24, 25);
    for (int p = 0; p < 12; p++) cycle(0, '0, 0, 1, pa[p], pb[p]);
    check_value("restart_no_done", 32'(done_count - done_before), 32'd0);
    cycle(0, '0, 0, 1, pa[12], pb[12]);
    check_value("restart_done", 32'(done_count - done_before), 32'd1);
    idle(1);
    translate_const("restart_map", 0, 20);

    // Randomized traffic, biased toward pairs that complete a load.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] oh;
      bit st, cv;
      oh = ($urandom_range(0, 9) == 0) ? N'($urandom()) : letter($urandom_range(0, N - 1));
      st = ($urandom_range(0, 59) == 0);
      cv = ($urandom_range(0, 3) != 0);
      q.delete();
      for (int i = 0; i < N; i++) if (!used_m[i]) q.push_back(i);
      if (q.size() >= 2 && $urandom_range(0, 49) != 0) begin
        x = $urandom_range(0, q.size() - 1);
        y = $urandom_range(0, q.size() - 2);
        if (y >= x) y++;
        x = q[x];
        y = q[y];
      end else begin
        x = $urandom_range(0, 31);
        y = $urandom_range(0, 31);
      end
      cycle($urandom_range(0, 1), oh, st, cv, x, y);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end
endmodule
